// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and the datapath/memory side.
// The controller uses the master view; the datapath (or a bench) uses the slave view.
interface multicycle_control_if;
  logic [15:0] input_instr;
  logic        input_MemReady;
  logic        input_Zero;
  logic        input_Negative;

  logic        output_PCWrite;
  logic        output_IRWrite;
  logic        output_IorD;
  logic        output_MemRead;
  logic        output_MemWrite;
  logic        output_RegWrite;
  logic        output_MemtoReg;
  logic [1:0]  output_ALUSrcA;
  logic [1:0]  output_ALUSrcB;
  logic [3:0]  output_ALUOp;
  logic        output_PCSrc;
  logic [3:0]  output_state;
  logic [15:0] output_retired;
  logic        output_halted;
  logic        output_illegal;

  modport master (
    input  input_instr, input_MemReady, input_Zero, input_Negative,
    output output_PCWrite, output_IRWrite, output_IorD, output_MemRead,
           output_MemWrite, output_RegWrite, output_MemtoReg, output_ALUSrcA,
           output_ALUSrcB, output_ALUOp, output_PCSrc, output_state,
           output_retired, output_halted, output_illegal
  );

  modport slave (
    output input_instr, input_MemReady, input_Zero, input_Negative,
    input  output_PCWrite, output_IRWrite, output_IorD, output_MemRead,
           output_MemWrite, output_RegWrite, output_MemtoReg, output_ALUSrcA,
           output_ALUSrcB, output_ALUOp, output_PCSrc, output_state,
           output_retired, output_halted, output_illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Control FSM of the 16-bit multi-cycle processor: sequences fetch/decode/execute/
// memory/writeback, drives the calculation-stage selects and counts retired instructions.
module multicycle_control #(
  parameter logic [3:0] ALUOP_ADD   = 4'h0,
  parameter logic [3:0] ALUOP_SUB   = 4'h1,
  parameter logic [3:0] ALUOP_PASSA = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'd0,
    OP_ADDI  = 4'd1,
    OP_LW    = 4'd2,
    OP_SW    = 4'd3,
    OP_BEQ   = 4'd4,
    OP_BLT   = 4'd5,
    OP_JUMP  = 4'd6,
    OP_HALT  = 4'd7
  } opcode_e;

  state_e      state_q, state_d;
  logic [15:0] retired_q, retired_d;

  logic [3:0]  opcode;
  logic [3:0]  funct;
  logic        retire;

  logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic        reg_write, mem_to_reg, pc_src, halted, illegal;
  logic [1:0]  alu_src_a, alu_src_b;
  logic [3:0]  alu_op;

  assign opcode = bus.input_instr[15:12];
  assign funct  = bus.input_instr[3:0];

  // Immediate bits belong to the datapath; only opcode and funct steer control.
  logic unused_instr;
  assign unused_instr = &{1'b0, bus.input_instr[11:4]};

  // NOTE: every always_comb output is defaulted first so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = ALUOP_ADD;

    unique case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = bus.input_MemReady;
        pc_write  = bus.input_MemReady;
        if (bus.input_MemReady) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'd2;
        unique case (opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_ADDR;
          OP_BEQ, OP_BLT: state_d = S_BRANCH;
          OP_JUMP:       state_d = S_JUMP;
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = 2'd2;
        alu_op    = funct;
        state_d   = S_WB_ALU;
      end

      S_EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
        state_d   = S_WB_ALU;
      end

      S_ADDR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (bus.input_MemReady) state_d = S_WB_MEM;
      end

      S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (bus.input_MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end

      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end

      S_BRANCH: begin
        // Mealy: the flags of this cycle's compare decide the PC load.
        alu_src_a = 2'd2;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_write  = (opcode == OP_BLT) ? bus.input_Negative : bus.input_Zero;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end

      S_JUMP: begin
        alu_src_a = 2'd3;
        alu_op    = ALUOP_PASSA;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_INIT;
    endcase

    retired_d = retire ? retired_q + 16'd1 : retired_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign bus.output_PCWrite  = pc_write;
  assign bus.output_IRWrite  = ir_write;
  assign bus.output_IorD     = i_or_d;
  assign bus.output_MemRead  = mem_read;
  assign bus.output_MemWrite = mem_write;
  assign bus.output_RegWrite = reg_write;
  assign bus.output_MemtoReg = mem_to_reg;
  assign bus.output_ALUSrcA  = alu_src_a;
  assign bus.output_ALUSrcB  = alu_src_b;
  assign bus.output_ALUOp    = alu_op;
  assign bus.output_PCSrc    = pc_src;
  assign bus.output_state    = state_q;
  assign bus.output_retired  = retired_q;
  assign bus.output_halted   = halted;
  assign bus.output_illegal  = illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: walks each instruction through its
// expected state path and compares every cycle's outputs against a behavioural model.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_retired;
  logic        fix_flags = 1'b0;
  logic        fz = 1'b0;
  logic        fn = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] obs_vec();
    return {bus.output_PCWrite, bus.output_IRWrite, bus.output_IorD, bus.output_MemRead,
            bus.output_MemWrite, bus.output_RegWrite, bus.output_MemtoReg,
            bus.output_ALUSrcA, bus.output_ALUSrcB, bus.output_ALUOp,
            bus.output_PCSrc, bus.output_halted, bus.output_illegal};
  endfunction

  // Expected control outputs for a state, straight from the per-state output rules.
  function automatic logic [19:0] exp_out(input int st, input logic [15:0] ins,
                                          input logic rdy, input logic z, input logic n);
    logic pw = 0, irw = 0, iord = 0, mr = 0, mw = 0, rw = 0, m2r = 0, pcs = 0, h = 0, ill = 0;
    logic [1:0] sa = 0, sb = 0;
    logic [3:0] op = 4'h0;
    logic [3:0] opc = ins[15:12];
    case (st)
      1:  begin mr = 1; sb = 1; irw = rdy; pw = rdy; end
      2:  begin sb = 2; ill = (opc > 4'd7); end
      3:  begin sa = 2; op = ins[3:0]; end
      4, 5: begin sa = 2; sb = 2; end
      6:  begin iord = 1; mr = 1; end
      7:  begin iord = 1; mw = 1; end
      8:  rw = 1;
      9:  begin rw = 1; m2r = 1; end
      10: begin sa = 2; op = 4'h1; pcs = 1; pw = (opc == 4'd5) ? n : z; end
      11: begin sa = 3; op = 4'hF; pw = 1; end
      12: h = 1;
      default: ;
    endcase
    return {pw, irw, iord, mr, mw, rw, m2r, sa, sb, op, pcs, h, ill};
  endfunction

  // One clock cycle: called just after a falling edge, returns at the next falling edge.
  task automatic cycle(input int st, input logic rdy);
    logic z, n;
    if (fix_flags) begin
      z = fz;
      n = fn;
    end else begin
      z = 1'($urandom_range(0, 1));
      n = 1'($urandom_range(0, 1));
    end
    bus.input_MemReady = rdy;
    bus.input_Zero     = z;
    bus.input_Negative = n;
    #1;
    check($sformatf("state_s%0d", st), 32'(bus.output_state), 32'(st));
    check($sformatf("outputs_s%0d", st), 32'(obs_vec()), 32'(exp_out(st, bus.input_instr, rdy, z, n)));
    check($sformatf("retired_s%0d", st), 32'(bus.output_retired), 32'(m_retired));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walk one instruction: path from the opcode table, memory states stall on MemReady.
  task automatic run_instr(input logic [15:0] ins, input int fstall, input int mstall,
                           input bit rnd, output int cyc);
    int path[$];
    logic [3:0] opc = ins[15:12];
    bus.input_instr = ins;
    path = {1, 2};
    case (opc)
      4'd0: path = {path, 3, 8};
      4'd1: path = {path, 4, 8};
      4'd2: path = {path, 5, 6, 9};
      4'd3: path = {path, 5, 7};
      4'd4, 4'd5: path.push_back(10);
      4'd6: path.push_back(11);
      default: ;
    endcase
    cyc = 0;
    foreach (path[i]) begin
      int st = path[i];
      if (st == 1 || st == 6 || st == 7) begin
        int k = rnd ? int'($urandom_range(0, 2)) : ((st == 1) ? fstall : mstall);
        repeat (k) begin
          cycle(st, 1'b0);
          cyc++;
        end
        cycle(st, 1'b1);
        cyc++;
      end else begin
        cycle(st, 1'($urandom_range(0, 1)));
        cyc++;
      end
    end
    if (opc < 4'd8) m_retired = m_retired + 16'd1;
  endtask

  initial begin
    int cyc;
    logic [31:0] r;
    logic [3:0] opc;

    bus.input_instr    = 16'h0000;
    bus.input_MemReady = 1'b0;
    bus.input_Zero     = 1'b0;
    bus.input_Negative = 1'b0;
    m_retired = 16'd0;

    reset = 1'b0;
    #2;
    check("reset_state", 32'(bus.output_state), 32'd0);
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    check("reset_retired", 32'(bus.output_retired), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 1'b1);

    // R-type ADD with memory always ready
    run_instr(16'h0120, 0, 0, 1'b0, cyc);
    check("cycles_rtype", 32'(cyc), 32'd4);
    check("retired_after_rtype", 32'(m_retired), 32'd1);

    // LW with three wait cycles in MEM_RD
    run_instr(16'h2345, 0, 3, 1'b0, cyc);
    check("cycles_lw_stall", 32'(cyc), 32'd8);

    // BEQ taken and not taken
    fix_flags = 1'b1;
    fz = 1'b1;
    fn = 1'b0;
    run_instr(16'h4123, 0, 0, 1'b0, cyc);
    check("cycles_beq_taken", 32'(cyc), 32'd3);
    fz = 1'b0;
    fn = 1'b1;
    run_instr(16'h4123, 0, 0, 1'b0, cyc);
    check("cycles_beq_not_taken", 32'(cyc), 32'd3);
    // BLT follows Negative, not Zero
    fz = 1'b0;
    fn = 1'b1;
    run_instr(16'h5123, 0, 0, 1'b0, cyc);
    check("cycles_blt", 32'(cyc), 32'd3);
    fix_flags = 1'b0;

    // Illegal opcode: one-cycle pulse in DECODE, not retired
    run_instr(16'hA000, 0, 0, 1'b0, cyc);
    check("cycles_illegal", 32'(cyc), 32'd2);
    check("retired_after_illegal", 32'(bus.output_retired), 32'(m_retired));

    // SW, ADDI, JUMP with ready tied high
    run_instr(16'h3001, 0, 0, 1'b0, cyc);
    check("cycles_sw", 32'(cyc), 32'd4);
    run_instr(16'h1abc, 0, 0, 1'b0, cyc);
    check("cycles_addi", 32'(cyc), 32'd4);
    run_instr(16'h6fff, 0, 0, 1'b0, cyc);
    check("cycles_jump", 32'(cyc), 32'd3);

    // Random instruction mix (no HALT) with random memory stalls
    repeat (150) begin
      r = $urandom();
      opc = r[15:12];
      if (opc == 4'd7) opc = 4'd6;
      run_instr({opc, r[11:0]}, 0, 0, 1'b1, cyc);
    end

    // Reset asserted mid-MEM_RD aborts the load
    bus.input_instr = 16'h2000;
    cycle(1, 1'b1);
    cycle(2, 1'b1);
    cycle(5, 1'b1);
    bus.input_MemReady = 1'b0;
    #1;
    check("pre_abort_state", 32'(bus.output_state), 32'd6);
    #2;
    reset = 1'b0;
    #1;
    check("abort_state", 32'(bus.output_state), 32'd0);
    check("abort_outputs", 32'(obs_vec()), 32'd0);
    check("abort_retired", 32'(bus.output_retired), 32'd0);
    m_retired = 16'd0;
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 1'b1);

    // Counter wrap: preload near the top while FETCH is stalled
    force dut.retired_q = 16'hFFFE;
    m_retired = 16'hFFFE;
    bus.input_instr = 16'h6000;
    cycle(1, 1'b0);
    cycle(1, 1'b0);
    release dut.retired_q;
    run_instr(16'h6000, 0, 0, 1'b0, cyc);
    check("retired_ffff", 32'(m_retired), 32'hFFFF);
    run_instr(16'h6000, 1, 0, 1'b0, cyc);
    check("cycles_jump_fstall", 32'(cyc), 32'd4);
    check("retired_wrapped", 32'(bus.output_retired), 32'h0000);

    // HALT retires once and then holds
    run_instr(16'h7000, 0, 0, 1'b0, cyc);
    repeat (100) cycle(12, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy control FSM for the 16-bit multi-cycle processor.
- Sits directly upstream of the datapath calculation stage: decodes the latched instruction, sequences fetch/decode/execute/memory/writeback, and drives that stage's ALUOp, ALUSrcA, ALUSrcB and PCSrc selects.
- Consumes the stage's Zero/Negative flags to qualify branches.
- Holds in memory states on a ready handshake; counts retired instructions.

Parameters:
- ALUOP_ADD, 4'h0, ALU opcode for addition
- ALUOP_SUB, 4'h1, ALU opcode for subtraction (branch compare)
- ALUOP_PASSA, 4'hF, ALU opcode passing input A unchanged (jump)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- input_instr  input  16  instruction register contents; [15:12] opcode, [3:0] funct
- input_MemReady  input  1  memory access completes this cycle
- input_Zero  input  1  ALU zero flag (combinational, same cycle)
- input_Negative  input  1  ALU negative flag (unused except by BLT)
- output_PCWrite  output  1  PC load enable
- output_IRWrite  output  1  instruction register load
- output_IorD  output  1  0 = PC addresses memory, 1 = ALUOut
- output_MemRead  output  1  memory read request
- output_MemWrite  output  1  memory write request
- output_RegWrite  output  1  register file write enable
- output_MemtoReg  output  1  1 = writeback from memory data, 0 = ALUOut
- output_ALUSrcA  output  2  0 PC, 1 const 2, 2 A, 3 imm
- output_ALUSrcB  output  2  0 B, 1 const 1, 2 imm
- output_ALUOp  output  4  ALU operation
- output_PCSrc  output  1  0 ALU result, 1 ALUOut
- output_state  output  4  current state encoding (debug)
- output_retired  output  16  retired-instruction count
- output_halted  output  1  FSM in HALT
- output_illegal  output  1  one-cycle pulse on undefined opcode

Behaviour:
- Opcodes: 0 R-type (ALUOp = funct), 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BLT, 6 JUMP, 7 HALT, 8-15 illegal.
- States: INIT=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JUMP=11, HALT=12.
- Reset (reset=0, async): state INIT, output_retired=0, all enables/selects 0, output_illegal=0. INIT → FETCH on the next clock after reset deasserts. Reset mid-instruction aborts it with no writes.
- Unlisted outputs are 0 in every state.
- FETCH:
  - IorD=0, MemRead=1, SrcA=0, SrcB=1, ALUOp=ADD, PCSrc=0.
  - IRWrite=PCWrite=input_MemReady.
  - Holds while MemReady=0; → DECODE on MemReady=1. PC word-increments by 1.
- DECODE: SrcA=0, SrcB=2, ALUOp=ADD (branch target into ALUOut). Next state by opcode:
  - 0 → EXEC_R; 1 → EXEC_I; 2, 3 → ADDR; 4, 5 → BRANCH; 6 → JUMP; 7 → HALT.
  - illegal → FETCH, with output_illegal=1 for this cycle and not retired.
- EXEC_R: SrcA=2, SrcB=0, ALUOp=input_instr[3:0] → WB_ALU.
- EXEC_I: SrcA=2, SrcB=2, ALUOp=ADD → WB_ALU.
- ADDR: SrcA=2, SrcB=2, ALUOp=ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: IorD=1, MemRead=1. Hold until MemReady → WB_MEM.
- MEM_WR: IorD=1, MemWrite=1. Hold until MemReady → FETCH, retire.
- WB_ALU: RegWrite=1, MemtoReg=0 → FETCH, retire.
- WB_MEM: RegWrite=1, MemtoReg=1 → FETCH, retire.
- BRANCH:
  - SrcA=2, SrcB=0, ALUOp=SUB, PCSrc=1.
  - PCWrite = input_Zero (BEQ) or input_Negative (BLT); Mealy, same cycle.
  - → FETCH, retire whether taken or not.
- JUMP: SrcA=3, ALUOp=PASSA, PCSrc=0, PCWrite=1 → FETCH, retire.
- HALT: output_halted=1. Terminal until reset; retires once on entry from DECODE.
- Retire counter: +1 on the clock edge leaving the final state of an instruction; wraps 16'hFFFF → 0.
- Cycle counts with MemReady tied 1:
  - R, ADDI, SW: 4
  - LW: 5
  - BEQ/BLT, JUMP: 3
- Each MemReady=0 cycle adds one cycle. MemRead and MemWrite are never asserted together.

Test Plan:
- Reset: drop reset mid-MEM_RD → outputs 0 immediately, state=0, retired=0. Release → FETCH one clock later.
- ADD R-type (instr 16'h0120, ready=1) → states 1,2,3,8,1. ALUOp=0 in EXEC_R; RegWrite=1 only in WB_ALU; retired=1 after 4 cycles.
- LW with MemReady held 0 for 3 cycles in MEM_RD → MemRead, IorD=1 stay asserted. WB_MEM reached 1 cycle after ready; total 8 cycles; MemtoReg=1 during RegWrite.
- BEQ: Zero=1 → PCWrite=1, PCSrc=1 in BRANCH. Zero=0 → PCWrite=0. Both retire, 3 cycles each.
- Opcode 4'hA → illegal pulse for exactly 1 cycle in DECODE, back to FETCH, retired unchanged.
- Counter wrap: preload via 65535 JUMPs (or force) → next retire gives 0. HALT → halted=1 and FSM stays in HALT for 100 cycles.
